// File: rtl/fixed_subframe_sequencer_pkg.sv
// Shared types and default widths for the FLAC FIXED subframe sequencer.
package fixed_subframe_sequencer_pkg;

  localparam int unsigned DataWidth  = 16;
  localparam int unsigned BlockWidth = 16;
  localparam int unsigned MaxOrder   = 4;
  localparam int unsigned OrderWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDrain
  } seq_state_e;

endpackage

// File: rtl/fixed_subframe_sequencer_sat_counter16.sv
// 16-bit saturating event counter with synchronous clear; used for stall statistics.
module sat_counter16 (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iClear,
  input  logic        iEnable,
  output logic [15:0] oCount
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (iClear) begin
      count_d = '0;
    end else if (iEnable && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oCount = count_q;

endmodule

// File: rtl/fixed_subframe_sequencer.sv
// Sequences one FLAC FIXED subframe into the fixed-predictor decode pipe.
// Define FIXED_SEQ_STATS_EN to add the oStallCycles input-starvation counter.
module fixed_subframe_sequencer
  import fixed_subframe_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W    = DataWidth,
  parameter int unsigned BLOCK_W   = BlockWidth,
  parameter int unsigned MAX_ORDER = MaxOrder
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iStart,
  input  logic [OrderWidth-1:0] iOrder,
  input  logic [BLOCK_W-1:0]    iBlockSize,
  input  logic [DATA_W-1:0]     iSample,
  input  logic                  iSampleValid,
  output logic                  oSampleReady,
  output logic                  oPipeReset,
  output logic                  oPipeEnable,
  output logic [OrderWidth-1:0] oPipeOrder,
  output logic [DATA_W-1:0]     oPipeSample,
  input  logic [DATA_W-1:0]     iPipeData,
  output logic [DATA_W-1:0]     oData,
  output logic                  oDataValid,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError
`ifdef FIXED_SEQ_STATS_EN
  ,
  output logic [15:0]           oStallCycles
`endif
);

  seq_state_e            state_q, state_d;
  logic [OrderWidth-1:0] order_q, order_d;
  logic [BLOCK_W-1:0]    size_q, size_d;
  logic [BLOCK_W-1:0]    remaining_q, remaining_d;
  logic                  data_valid_q;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  start_bad;

  assign start_bad = (32'(iOrder) > MAX_ORDER) || (iBlockSize == '0);

  always_comb begin
    state_d      = state_q;
    order_d      = order_q;
    size_d       = size_q;
    remaining_d  = remaining_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    oSampleReady = 1'b0;
    oPipeReset   = 1'b0;
    oPipeEnable  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          if (start_bad) begin
            error_d = 1'b1;
          end else begin
            order_d = iOrder;
            size_d  = iBlockSize;
            state_d = StClear;
          end
        end
      end
      StClear: begin
        oPipeReset  = 1'b1;
        remaining_d = size_q;
        state_d     = StRun;
      end
      StRun: begin
        oSampleReady = 1'b1;
        if (iSampleValid) begin
          oPipeEnable = 1'b1;
          remaining_d = remaining_q - BLOCK_W'(1);
          if (remaining_q == BLOCK_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Last decoded sample is presented this cycle; done follows in IDLE.
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= StIdle;
      order_q      <= '0;
      size_q       <= '0;
      remaining_q  <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      order_q      <= order_d;
      size_q       <= size_d;
      remaining_q  <= remaining_d;
      data_valid_q <= oPipeEnable;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign oPipeOrder  = order_q;
  assign oPipeSample = iSample;
  assign oData       = iPipeData;
  assign oDataValid  = data_valid_q;
  assign oBusy       = (state_q != StIdle);
  assign oDone       = done_q;
  assign oError      = error_q;

`ifdef FIXED_SEQ_STATS_EN
  sat_counter16 u_stall_counter (
    .iClock (iClock),
    .iReset (iReset),
    .iClear ((state_q == StIdle) && (state_d == StClear)),
    .iEnable((state_q == StRun) && !iSampleValid),
    .oCount (oStallCycles)
  );
`endif

endmodule

// File: tb/tb_fixed_subframe_sequencer.sv
// Randomized self-checking bench for fixed_subframe_sequencer with a behavioural decode pipe.
// Define FIXED_SEQ_STATS_EN to also check oStallCycles.
module tb_fixed_subframe_sequencer;

  logic        iClock = 1'b0;
  logic        iReset, iStart, iSampleValid;
  logic [3:0]  iOrder;
  logic [15:0] iBlockSize, iSample, iPipeData;
  logic        oSampleReady, oPipeReset, oPipeEnable;
  logic [3:0]  oPipeOrder;
  logic [15:0] oPipeSample, oData;
  logic        oDataValid, oBusy, oDone, oError;
`ifdef FIXED_SEQ_STATS_EN
  logic [15:0] oStallCycles;
`endif

  int checks = 0;
  int errors = 0;
  int samp[16];
  int gap[16];
  int exp_out[16];

  always #5 iClock = ~iClock;

  fixed_subframe_sequencer dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iStart      (iStart),
    .iOrder      (iOrder),
    .iBlockSize  (iBlockSize),
    .iSample     (iSample),
    .iSampleValid(iSampleValid),
    .oSampleReady(oSampleReady),
    .oPipeReset  (oPipeReset),
    .oPipeEnable (oPipeEnable),
    .oPipeOrder  (oPipeOrder),
    .oPipeSample (oPipeSample),
    .iPipeData   (iPipeData),
    .oData       (oData),
    .oDataValid  (oDataValid),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oError      (oError)
`ifdef FIXED_SEQ_STATS_EN
    ,
    .oStallCycles(oStallCycles)
`endif
  );

  // Behavioural fixed-predictor pipe: one-cycle latency, warmup passes straight through.
  logic [15:0] h1 = '0, h2 = '0, h3 = '0, h4 = '0;
  logic [15:0] pipe_out = '0;
  logic [15:0] pipe_y;
  int          pcnt = 0;

  function automatic logic [15:0] pipe_step(input logic [3:0] order, input int cnt,
                                            input logic [15:0] s, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] c,
                                            input logic [15:0] d);
    if (cnt < int'(order)) return s;
    case (order)
      4'd1:    return 16'(s + a);
      4'd2:    return 16'(s + 2 * a - b);
      4'd3:    return 16'(s + 3 * a - 3 * b + c);
      4'd4:    return 16'(s + 4 * a - 6 * b + 4 * c - d);
      default: return s;
    endcase
  endfunction

  always_comb pipe_y = pipe_step(oPipeOrder, pcnt, oPipeSample, h1, h2, h3, h4);

  always @(posedge iClock) begin
    if (oPipeReset) begin
      pcnt <= 0;
      h1 <= '0; h2 <= '0; h3 <= '0; h4 <= '0;
    end else if (oPipeEnable) begin
      pipe_out <= pipe_y;
      h1 <= pipe_y; h2 <= h1; h3 <= h2; h4 <= h3;
      pcnt <= pcnt + 1;
    end
  end

  assign iPipeData = pipe_out;

  // Reference: whole-subframe fixed-predictor recurrence on plain integers.
  function automatic void build_expected(input int order, input int size);
    int x[16];
    for (int n = 0; n < size; n++) begin
      if (n < order) x[n] = samp[n];
      else begin
        case (order)
          1:       x[n] = samp[n] + x[n-1];
          2:       x[n] = samp[n] + 2 * x[n-1] - x[n-2];
          3:       x[n] = samp[n] + 3 * x[n-1] - 3 * x[n-2] + x[n-3];
          4:       x[n] = samp[n] + 4 * x[n-1] - 6 * x[n-2] + 4 * x[n-3] - x[n-4];
          default: x[n] = samp[n];
        endcase
      end
      exp_out[n] = x[n];
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge iClock);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic rdy, input logic en,
                              input logic prst, input logic dv, input logic done,
                              input logic busy, input logic err);
    @(negedge iClock);
    check_eq({tag, "/ready"}, 32'(oSampleReady), 32'(rdy));
    check_eq({tag, "/enable"}, 32'(oPipeEnable), 32'(en));
    check_eq({tag, "/pipe_reset"}, 32'(oPipeReset), 32'(prst));
    check_eq({tag, "/data_valid"}, 32'(oDataValid), 32'(dv));
    check_eq({tag, "/done"}, 32'(oDone), 32'(done));
    check_eq({tag, "/busy"}, 32'(oBusy), 32'(busy));
    check_eq({tag, "/error"}, 32'(oError), 32'(err));
  endtask

  task automatic check_data(input string tag, input int idx);
    int e;
    e = exp_out[idx];
    check_eq(tag, 32'(oData), 32'(e[15:0]));
  endtask

  task automatic run_subframe(input int order, input int size, input bit rand_data,
                              input bit poke);
    int  stalls;
    bit  prev;
    int  s;
    if (rand_data) begin
      for (int i = 0; i < size; i++) begin
        samp[i] = int'($urandom_range(0, 400)) - 200;
        gap[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
    end
    build_expected(order, size);
    stalls = 0;
    prev   = 1'b0;
    iStart = 1'b1; iOrder = order[3:0]; iBlockSize = size[15:0];
    iSampleValid = 1'($urandom_range(0, 1)); iSample = 16'($urandom);
    expect_cycle("start", 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    // Scramble request inputs to prove order/size were latched.
    iStart = poke; iOrder = 4'($urandom); iBlockSize = 16'($urandom);
    iSampleValid = 1'b1; iSample = 16'($urandom);
    expect_cycle("clear", 0, 0, 1, 0, 0, 1, 0);
    check_eq("clear/order", 32'(oPipeOrder), 32'(order));
    next_cycle();
    for (int i = 0; i < size; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        iStart = poke & 1'($urandom_range(0, 1)); iSampleValid = 1'b0;
        iSample = 16'($urandom);
        expect_cycle("run_gap", 1, 0, 0, prev, 0, 1, 0);
        if (prev) check_data("gap/data", i - 1);
        next_cycle();
        prev = 1'b0;
        stalls++;
      end
      s = samp[i];
      iStart = poke & 1'($urandom_range(0, 1)); iSampleValid = 1'b1; iSample = s[15:0];
      expect_cycle("run_xfer", 1, 1, 0, prev, 0, 1, 0);
      check_eq("xfer/pipe_sample", 32'(oPipeSample), 32'(s[15:0]));
      if (prev) check_data("xfer/data", i - 1);
      next_cycle();
      prev = 1'b1;
    end
    iStart = poke; iSampleValid = 1'b1; iSample = 16'($urandom);
    expect_cycle("drain", 0, 0, 0, 1, 0, 1, 0);
    check_data("drain/data", size - 1);
    next_cycle();
    iStart = 1'b0; iSampleValid = 1'b0;
    expect_cycle("done", 0, 0, 0, 0, 1, 0, 0);
`ifdef FIXED_SEQ_STATS_EN
    check_eq("done/stall_cycles", 32'(oStallCycles), 32'(stalls));
`endif
    next_cycle();
  endtask

  task automatic bad_start(input logic [3:0] order, input logic [15:0] size);
    iStart = 1'b1; iOrder = order; iBlockSize = size; iSampleValid = 1'b1;
    expect_cycle("bad_start", 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    iStart = 1'b0;
    expect_cycle("bad_err", 0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    iSampleValid = 1'b0;
    expect_cycle("bad_after", 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1; iStart = 1'b1; iOrder = 4'd2; iBlockSize = 16'd4;
    iSample = 16'h1234; iSampleValid = 1'b1;
    next_cycle();
    expect_cycle("reset", 0, 0, 0, 0, 0, 0, 0);
    check_eq("reset/order", 32'(oPipeOrder), 32'd0);
    next_cycle();
    iReset = 1'b0; iStart = 1'b0; iSampleValid = 1'b0;
    next_cycle();

    samp[0] = 5; samp[1] = 3; samp[2] = -2;
    gap[0] = 0; gap[1] = 0; gap[2] = 0;
    run_subframe(1, 3, 1'b0, 1'b0);

    samp[0] = 10; samp[1] = 12; samp[2] = 0; samp[3] = 1;
    gap[0] = 0; gap[1] = 0; gap[2] = 2; gap[3] = 0;
    run_subframe(2, 4, 1'b0, 1'b0);

    bad_start(4'd5, 16'd4);
    bad_start(4'd2, 16'd0);

    samp[0] = 7; samp[1] = 9; gap[0] = 0; gap[1] = 0;
    run_subframe(4, 2, 1'b0, 1'b0);

    // Reset in the middle of a 5-sample order-2 subframe.
    iStart = 1'b1; iOrder = 4'd2; iBlockSize = 16'd5; iSampleValid = 1'b0;
    expect_cycle("mid_start", 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    iStart = 1'b0;
    expect_cycle("mid_clear", 0, 0, 1, 0, 0, 1, 0);
    next_cycle();
    iSampleValid = 1'b1; iSample = 16'd11;
    expect_cycle("mid_x0", 1, 1, 0, 0, 0, 1, 0);
    next_cycle();
    iSample = 16'd22;
    expect_cycle("mid_x1", 1, 1, 0, 1, 0, 1, 0);
    next_cycle();
    iReset = 1'b1; iSampleValid = 1'b0;
    expect_cycle("mid_rst", 1, 0, 0, 1, 0, 1, 0);
    next_cycle();
    iReset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_cycle("post_rst", 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
    run_subframe(2, 5, 1'b1, 1'b0);

    // Start pulses while busy must not disturb the running subframe.
    run_subframe(3, 6, 1'b1, 1'b1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) bad_start(4'($urandom_range(5, 15)), 16'($urandom_range(1, 20)));
        else bad_start(4'($urandom_range(0, 4)), 16'd0);
      end else begin
        run_subframe(int'($urandom_range(0, 4)), int'($urandom_range(1, 8)), 1'b1,
                     1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_subframe_sequencer.md
Name: fixed_subframe_sequencer

Overview:
- Controller for one FLAC FIXED subframe: latches order and block size, pulses a clear into the fixed-predictor decode pipe, then streams warmup samples and residuals into it under a valid/ready handshake.
- Asserts the pipe enable exactly once per consumed input, tags each pipe output with a valid strobe, and reports done/error.
- Sits between the residual/warmup unpacker (upstream) and the fixed decode pipe plus the channel output buffer (downstream).

Parameters:
- DATA_W, 16, sample/residual width (signed).
- BLOCK_W, 16, block-size counter width.
- MAX_ORDER, 4, highest legal fixed predictor order.

Ports:
- iClock  in  1  clock
- iReset  in  1  synchronous active-high reset
- iStart  in  1  one-cycle start; sampled only in IDLE
- iOrder  in  4  predictor order, latched on accepted iStart
- iBlockSize  in  BLOCK_W  samples in subframe (warmup + residual), latched on iStart
- iSample  in  DATA_W  warmup sample or residual from unpacker
- iSampleValid  in  1  iSample valid
- oSampleReady  out  1  sequencer accepts iSample this cycle
- oPipeReset  out  1  clear strobe to decode pipe
- oPipeEnable  out  1  pipe advance strobe
- oPipeOrder  out  4  latched order to pipe
- oPipeSample  out  DATA_W  sample to pipe (iSample registered-through, combinational pass)
- iPipeData  in  DATA_W  decoded sample from pipe
- oData  out  DATA_W  decoded sample (= iPipeData)
- oDataValid  out  1  oData holds a new decoded sample
- oBusy  out  1  high outside IDLE
- oDone  out  1  one-cycle pulse after last sample's oDataValid
- oError  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: state IDLE; all strobes 0; oPipeOrder 0; counters 0; oBusy 0. Reset wins over every other input, including mid-RUN; discards the subframe with no oDone.
- States: IDLE -> CLEAR -> RUN -> DRAIN -> IDLE.
- IDLE, iStart=1:
  - iOrder > MAX_ORDER or iBlockSize == 0: oError pulses next cycle, stay IDLE, no pipe activity.
  - Otherwise latch order/size and go to CLEAR.
- CLEAR: oPipeReset=1 for exactly one cycle; remaining := block size; -> RUN.
- RUN:
  - oSampleReady = 1.
  - Transfer when iSampleValid & oSampleReady: oPipeEnable=1 same cycle, oPipeSample=iSample, remaining decrements.
  - Transfer with remaining==1 -> DRAIN.
  - No transfer -> oPipeEnable=0; pipe holds state.
- DRAIN: one cycle, oSampleReady=0, then IDLE with oDone=1 that cycle.
- oDataValid: register of oPipeEnable, i.e. valid 1 cycle after the transfer (pipe latency 1). oData is combinational from iPipeData.
- Input ordering: the first min(order, blocksize) transfers are warmup; the pipe tracks warmup internally. The sequencer does not distinguish warmup from residual, and blocksize < order is legal (all samples are warmup).
- oDone asserts in the same cycle as the last oDataValid +1, i.e. the cycle after the final oDataValid.
- iStart outside IDLE: ignored, no error.
- Throughput: 1 sample/cycle at full iSampleValid. Back-to-back subframes cost 2 idle cycles (DRAIN, IDLE->CLEAR) plus the CLEAR cycle.
- No downstream backpressure; the consumer must accept every oDataValid.

Optional Feature:
- FIXED_SEQ_STATS_EN defined: adds output oStallCycles (16 bits).
  - Counts RUN cycles with iSampleValid=0.
  - Saturates at 0xFFFF.
  - Cleared on iReset and on entry to CLEAR.
  - Holds its value in IDLE.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, RUN, DRAIN), MAX_ORDER constant, DATA_W/BLOCK_W widths.
- Optional stall counter as sub-module sat_counter16 (enable, clear, saturating). Everything else stays in one FSM module.

Test Plan:
- Order 1, size 3, inputs 5,3,-2 streamed continuously -> oPipeReset one pulse; oData 5,8,6 on three consecutive oDataValid cycles; oDone the cycle after the third.
- Order 2, size 4, inputs 10,12,0,1 with iSampleValid low for 2 cycles between 12 and 0 -> outputs 10,12,14,17; oPipeEnable only on transfers; stats build: oStallCycles=2.
- iOrder=5 or iBlockSize=0 with iStart -> oError pulse, oBusy stays 0, no oPipeEnable/oPipeReset.
- Order 4, size 2, inputs 7,9 -> outputs 7,9 (warmup only), oDone after second.
- iReset asserted mid-RUN after 2 of 5 samples -> next cycle IDLE, oSampleReady=0, no oDone; a new start then produces a correct full subframe.
- iStart pulsed during RUN -> ignored; the current subframe completes with an unchanged sample count.
